// File: rtl/dds_lut_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dds_lut_scheduler_pkg
// Description : Shared widths, quadrant encoding and scheduler state type for
//               the two-channel quarter-wave DDS sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package dds_lut_scheduler_pkg;

  localparam int DEF_PHASE_W     = 24;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_LUT_LATENCY = 1;

  // Quadrant of the folded phase (top two lookup bits)
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  // LUT scheduler states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/dds_lut_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface   : dds_lut_scheduler_if
// Description : FTW write handshake, shared LUT port and sample output of the
//               DDS LUT scheduler. slave = scheduler, master = environment
//               (config path, LUT memory and sample sink).
// Revision    : 1.0 - initial release
// ============================================================================
interface dds_lut_scheduler_if #(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  logic                enable;
  logic [PHASE_W-1:0]  ftw_in;
  logic                ftw_ch;
  logic                ftw_valid;
  logic                ftw_ready;
  logic [ADDR_W-3:0]   lut_addr;
  logic [DATA_W-2:0]   lut_data;
  logic [DATA_W-1:0]   sample_out;
  logic                sample_ch;
  logic                sample_valid;

  modport master (
    output enable, ftw_in, ftw_ch, ftw_valid, lut_data,
    input  ftw_ready, lut_addr, sample_out, sample_ch, sample_valid
  );

  modport slave (
    input  enable, ftw_in, ftw_ch, ftw_valid, lut_data,
    output ftw_ready, lut_addr, sample_out, sample_ch, sample_valid
  );
endinterface
`default_nettype wire

// File: rtl/dds_quadrant_fold.sv
`default_nettype none
// ============================================================================
// Module      : dds_quadrant_fold
// Description : Folds the top phase bits into a quarter-wave LUT index and a
//               sign. Odd quadrants walk the table backwards, the upper half
//               of the cycle is negative.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_quadrant_fold
  import dds_lut_scheduler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] phase_msb,
  output logic [ADDR_W-3:0] index,
  output logic              negative
);

  quadrant_t quad;
  assign quad = quadrant_t'(phase_msb[ADDR_W-1 -: 2]);

  // Mirror the index in odd quadrants, negate in quadrants 2 and 3
  always_comb begin
    index    = phase_msb[ADDR_W-3:0];
    negative = 1'b0;
    case (quad)
      Q0: ;
      Q1: index = ~phase_msb[ADDR_W-3:0];
      Q2: negative = 1'b1;
      Q3: begin
        index    = ~phase_msb[ADDR_W-3:0];
        negative = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dds_lut_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dds_lut_scheduler
// Description : Two-channel DDS that time-shares one registered quarter-wave
//               sine LUT. Slot 0 reads for channel 0, slot 1 for channel 1;
//               phases advance and staged FTWs take effect at frame end.
//               Optional macro DDS_PHASE_CLR_EN adds a phase_clr input for a
//               phase-coherent restart of both channels.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_lut_scheduler
  import dds_lut_scheduler_pkg::*;
#(
  parameter int PHASE_W     = DEF_PHASE_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LUT_LATENCY = DEF_LUT_LATENCY
) (
  input  logic clk,
  input  logic rst,
`ifdef DDS_PHASE_CLR_EN
  input  logic phase_clr,
`endif
  dds_lut_scheduler_if.slave bus
);

  sched_state_t       state, state_next;
  logic               slot, slot_next;
  logic [PHASE_W-1:0] phase   [2];
  logic [PHASE_W-1:0] ftw     [2];
  logic [PHASE_W-1:0] shadow  [2];
  logic               pending [2];

  logic issue;     // a LUT read is issued this cycle for channel `slot`
  logic boundary;  // last cycle of a frame
  logic apply;     // staged FTWs / phase clear may take effect this cycle
  logic accept;
  logic clr_now;

  assign issue         = (state == RUN);
  assign boundary      = issue & slot;
  assign apply         = boundary | (state == IDLE);
  assign bus.ftw_ready = !rst & !pending[bus.ftw_ch];
  assign accept        = bus.ftw_valid & bus.ftw_ready;

  // Scheduler state and slot register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      slot  <= 1'b0;
    end else begin
      state <= state_next;
      slot  <= slot_next;
    end
  end

  // Next state: a started frame always runs through slot 1
  always_comb begin
    state_next = state;
    slot_next  = 1'b0;
    case (state)
      IDLE: if (bus.enable) state_next = RUN;
      RUN: begin
        slot_next = ~slot;
        if (slot && !bus.enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef DDS_PHASE_CLR_EN
  logic clr_req;

  // Hold a clear request until the next point where phases may change
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_req <= 1'b0;
    end else begin
      if (apply)     clr_req <= 1'b0;
      if (phase_clr) clr_req <= 1'b1;
    end
  end

  assign clr_now = clr_req & apply;
`else
  assign clr_now = 1'b0;
`endif

  genvar c;
  generate
    for (c = 0; c < 2; c++) begin : g_chan
      // Per-channel phase accumulator, active FTW and staged FTW
      always_ff @(posedge clk) begin
        if (rst) begin
          phase[c]   <= '0;
          ftw[c]     <= '0;
          shadow[c]  <= '0;
          pending[c] <= 1'b0;
        end else begin
          if (clr_now)       phase[c] <= '0;
          else if (boundary) phase[c] <= phase[c] + ftw[c];
          // Load uses the old pending flag, so a write accepted in this
          // cycle is held over to the following boundary
          if (apply && pending[c]) begin
            ftw[c]     <= shadow[c];
            pending[c] <= 1'b0;
          end
          if (accept && (bus.ftw_ch == 1'(c))) begin
            shadow[c]  <= bus.ftw_in;
            pending[c] <= 1'b1;
          end
        end
      end
    end
  endgenerate

  logic [ADDR_W-1:0] phase_msb;
  logic [ADDR_W-3:0] fold_index;
  logic              fold_neg;

  assign phase_msb = phase[slot][PHASE_W-1 -: ADDR_W];

  dds_quadrant_fold #(.ADDR_W(ADDR_W)) u_fold (
    .phase_msb (phase_msb),
    .index     (fold_index),
    .negative  (fold_neg)
  );

  // Bit 0 of each shift register lines up with lut_addr, bit LUT_LATENCY
  // lines up with lut_data
  logic [LUT_LATENCY:0] neg_sr, ch_sr, vld_sr;

  // Registered LUT address and sign/channel/valid pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.lut_addr <= '0;
      neg_sr       <= '0;
      ch_sr        <= '0;
      vld_sr       <= '0;
    end else begin
      if (issue) bus.lut_addr <= fold_index;
      neg_sr <= {neg_sr[LUT_LATENCY-1:0], fold_neg};
      ch_sr  <= {ch_sr[LUT_LATENCY-1:0], slot};
      vld_sr <= {vld_sr[LUT_LATENCY-1:0], issue};
    end
  end

  logic [DATA_W-1:0] mag_ext;
  assign mag_ext = {1'b0, bus.lut_data};

  // Apply the sign to the LUT magnitude and register the sample
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sample_out   <= '0;
      bus.sample_ch    <= 1'b0;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.sample_valid <= vld_sr[LUT_LATENCY];
      if (vld_sr[LUT_LATENCY]) begin
        bus.sample_ch  <= ch_sr[LUT_LATENCY];
        bus.sample_out <= neg_sr[LUT_LATENCY] ? -mag_ext : mag_ext;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_lut_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_lut_scheduler
// Description : Directed bench for dds_lut_scheduler with an identity LUT
//               (mag[i] = i, one cycle read latency) and a sample scoreboard.
//               Build with DDS_PHASE_CLR_EN to also exercise phase_clr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_lut_scheduler;
  import dds_lut_scheduler_pkg::*;

  localparam logic [23:0] A_FTW = 24'h400000;

  logic clk = 1'b0;
  logic rst;
`ifdef DDS_PHASE_CLR_EN
  logic phase_clr;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [8:0] sb[$];

  dds_lut_scheduler_if #(.PHASE_W(24), .ADDR_W(8), .DATA_W(8)) bus ();

  dds_lut_scheduler #(
    .PHASE_W(24), .ADDR_W(8), .DATA_W(8), .LUT_LATENCY(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DDS_PHASE_CLR_EN
    .phase_clr (phase_clr),
`endif
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  // Identity quarter-wave LUT with a registered read
  always @(posedge clk) bus.lut_data <= {1'b0, bus.lut_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {channel, sample} for a given phase
  function automatic logic [8:0] exp_item(input logic ch, input logic [23:0] ph);
    logic [5:0] i;
    logic [7:0] v;
    i = ph[21:16];
    v = {2'b00, (ph[22] ? 6'd63 - i : i)};
    if (ph[23]) v = -v;
    return {ch, v};
  endfunction

  function automatic logic [5:0] exp_addr(input logic [23:0] ph);
    return ph[22] ? 6'd63 - ph[21:16] : ph[21:16];
  endfunction

  // Scoreboard: every valid sample must match the oldest expectation
  always @(negedge clk) begin
    if (bus.sample_valid === 1'b1) begin
      if (sb.size() == 0)
        check("unexpected sample", 32'({bus.sample_ch, bus.sample_out}), 32'hFFFFFFFF);
      else
        check("sample ch/value", 32'({bus.sample_ch, bus.sample_out}), 32'(sb.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    bus.enable    = 1'b0;
    bus.ftw_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic write_ftw(input logic ch, input logic [23:0] val);
    bus.ftw_ch    = ch;
    bus.ftw_in    = val;
    bus.ftw_valid = 1'b1;
    #1 check("ftw_ready idle", 32'(bus.ftw_ready), 32'd1);
    tick();
    bus.ftw_valid = 1'b0;
    tick();
    tick();
    check("ftw applied in idle", ch ? dut.ftw[1] : dut.ftw[0], 32'(val));
  endtask

  task automatic push_frames(input int n, input logic [23:0] f0, input logic [23:0] f1);
    for (int f = 0; f < n; f++) begin
      sb.push_back(exp_item(1'b0, 24'(f * f0)));
      sb.push_back(exp_item(1'b1, 24'(f * f1)));
    end
  endtask

  task automatic drain_check();
    repeat (4) tick();
    check("drain complete", 32'(sb.size()), 32'd0);
    check("quiet after drain", 32'(bus.sample_valid), 32'd0);
  endtask

  // Runs n frames from phase 0; enable drops during the last slot 0
  task automatic run_frames(input int n, input logic [23:0] f0);
    bus.enable = 1'b1;
    for (int k = 1; k <= 2 * n + 1; k++) begin
      tick();
      if (k == 2 * n - 1) bus.enable = 1'b0;
      if (k == 3) check("no sample before latency", 32'(bus.sample_valid), 32'd0);
      if (k == 4) check("first sample latency", 32'(bus.sample_valid), 32'd1);
      if (k % 2 == 0 && k <= 2 * n)
        check("lut_addr ch0", 32'(bus.lut_addr), 32'(exp_addr(24'((k / 2 - 1) * f0))));
    end
    check("idle after frame", 32'(dut.state), 32'(IDLE));
    drain_check();
  endtask

  initial begin
    rst           = 1'b1;
    bus.enable    = 1'b0;
    bus.ftw_in    = '0;
    bus.ftw_ch    = 1'b0;
    bus.ftw_valid = 1'b0;
`ifdef DDS_PHASE_CLR_EN
    phase_clr     = 1'b0;
`endif
    tick();
    tick();
    check("reset sample_valid", 32'(bus.sample_valid), 32'd0);
    check("reset sample_out", 32'(bus.sample_out), 32'd0);
    check("reset sample_ch", 32'(bus.sample_ch), 32'd0);
    check("reset lut_addr", 32'(bus.lut_addr), 32'd0);
    check("ftw_ready in reset", 32'(bus.ftw_ready), 32'd0);
    check("reset state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    #1 check("ftw_ready after reset", 32'(bus.ftw_ready), 32'd1);
    tick();

    // Quarter-turn steps on ch0, ch1 silent
    write_ftw(1'b0, A_FTW);
    push_frames(4, A_FTW, 24'h0);
    run_frames(4, A_FTW);

    // Single-step through the whole table and wrap
    do_reset();
    write_ftw(1'b0, 24'h010000);
    push_frames(258, 24'h010000, 24'h0);
    run_frames(258, 24'h010000);

    // FTW stall on ch0, independent write to ch1
    do_reset();
    for (int f = 0; f < 6; f++) begin
      sb.push_back(exp_item(1'b0, f >= 2 ? 24'((f - 2) * A_FTW) : 24'h0));
      sb.push_back(exp_item(1'b1, f >= 3 ? 24'((f - 3) * A_FTW) : 24'h0));
    end
    bus.enable = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 3) begin
        bus.ftw_ch = 1'b0; bus.ftw_in = A_FTW; bus.ftw_valid = 1'b1;
        #1 check("ftw_ready ch0 first", 32'(bus.ftw_ready), 32'd1);
      end
      if (k == 4) begin
        bus.ftw_in = 24'h123456;
        #1 check("ftw_ready ch0 stalled", 32'(bus.ftw_ready), 32'd0);
        bus.ftw_ch = 1'b1; bus.ftw_in = A_FTW;
        #1 check("ftw_ready ch1 free", 32'(bus.ftw_ready), 32'd1);
      end
      if (k == 5) begin
        bus.ftw_valid = 1'b0;
        #1 check("ftw_ready ch1 pending", 32'(bus.ftw_ready), 32'd0);
        bus.ftw_ch = 1'b0;
        #1 check("ftw_ready ch0 after boundary", 32'(bus.ftw_ready), 32'd1);
      end
      if (k == 11) bus.enable = 1'b0;
    end
    drain_check();

    // Reset with two lookups in flight
    do_reset();
    write_ftw(1'b0, A_FTW);
    bus.enable = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    check("phase advanced before reset", dut.phase[0], 32'(A_FTW));
    rst = 1'b1;
    bus.enable = 1'b0;
    tick();
    check("flush sample_valid", 32'(bus.sample_valid), 32'd0);
    check("flush lut_addr", 32'(bus.lut_addr), 32'd0);
    check("flush phase0", dut.phase[0], 32'd0);
    check("flush ftw0", dut.ftw[0], 32'd0);
    check("flush state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    #1 check("ftw_ready after flush", 32'(bus.ftw_ready), 32'd1);
    drain_check();

`ifdef DDS_PHASE_CLR_EN
    // Phase clear mid-frame restarts both channels at phase 0
    do_reset();
    write_ftw(1'b0, A_FTW);
    write_ftw(1'b1, A_FTW);
    for (int f = 0; f < 6; f++) begin
      sb.push_back(exp_item(1'b0, f < 2 ? 24'(f * A_FTW) : 24'((f - 2) * A_FTW)));
      sb.push_back(exp_item(1'b1, f < 2 ? 24'(f * A_FTW) : 24'((f - 2) * A_FTW)));
    end
    bus.enable = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 3) phase_clr = 1'b1;
      if (k == 4) phase_clr = 1'b0;
      if (k == 5) begin
        check("phase0 cleared", dut.phase[0], 32'd0);
        check("phase1 cleared", dut.phase[1], 32'd0);
      end
      if (k == 11) bus.enable = 1'b0;
    end
    drain_check();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
